force_release_bank: RTL and testbench

- Parametrised multi-channel force/release controller for self-checking benches and debug fabric.
- Each of NCH channels normally passes a driver value to its output; a command port can override the channel (force) and remove the override (release).
- Supports net mode (output reverts to driver on release) and variable mode (output holds the forced value until the next driver write).
- Adds timed forces that expire automatically, which the earlier single-signal release test has no notion of.

---
 rtl/force_release_pkg.sv | 21 ++
 rtl/force_release_bank_if.sv | 25 ++
 rtl/force_release_chan.sv | 74 +++++++
 rtl/force_release_bank.sv | 126 ++++++++++++
 tb/tb_force_release_bank.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/force_release_pkg.sv
// Shared encodings for the force/release bank: command opcodes, FSM states
// and the channel-index width helper.
package force_release_pkg;

    typedef enum logic [1:0] {
        OP_NOP         = 2'd0,
        OP_FORCE       = 2'd1,
        OP_RELEASE     = 2'd2,
        OP_RELEASE_ALL = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/force_release_bank_if.sv
// Command port of the force/release bank: one command per valid&ready beat;
// the bank deasserts ready for the cycle in which it applies a command.
interface force_release_bank_if #(
    parameter int NCH = 4,
    parameter int W   = 4,
    parameter int DW  = 8,
    parameter int CW  = force_release_pkg::chan_width(NCH)
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_chan;
    logic [W-1:0]  cmd_value;
    logic [DW-1:0] cmd_dur;

    modport master (
        output cmd_valid, cmd_op, cmd_chan, cmd_value, cmd_dur,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chan, cmd_value, cmd_dur,
        output cmd_ready
    );
endinterface

// File: rtl/force_release_chan.sv
// One channel: force value, duration timer, held (variable) value and output mux.
// Output registered one cycle after its inputs; no backpressure, acts on every strobe.
module force_release_chan #(
    parameter int W        = 4,
    parameter int DW       = 8,
    parameter int VAR_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          force_i,
    input  logic          release_i,
    input  logic [W-1:0]  fval_i,
    input  logic [DW-1:0] dur_i,
    input  logic [W-1:0]  drv_i,
    input  logic          we_i,
    output logic [W-1:0]  out_o,
    output logic          forced_o,
    output logic          expired_o
);
    logic [W-1:0]  fval_q, fval_d;
    logic [W-1:0]  held_q, held_d;
    logic [W-1:0]  out_q, out_d;
    logic [DW-1:0] timer_q, timer_d;
    logic          forced_q, forced_d;
    logic          expired_q;
    logic          expire;

    always_comb begin
        // A command landing on this channel pre-empts its own expiry.
        expire   = forced_q && (timer_q == DW'(1)) && !force_i && !release_i;
        forced_d = forced_q;
        fval_d   = fval_q;
        timer_d  = timer_q;
        held_d   = held_q;
        if (we_i && !forced_q) begin
            held_d = drv_i;
        end
        if (force_i) begin
            forced_d = 1'b1;
            fval_d   = fval_i;
            timer_d  = dur_i;
        end else if (release_i || expire) begin
            forced_d = 1'b0;
            timer_d  = '0;
            held_d   = fval_q;
        end else if (forced_q && (timer_q != '0)) begin
            timer_d = timer_q - DW'(1);
        end
        // Resolve from next-state so a force shows on the cycle after it is applied.
        out_d = forced_d ? fval_d : ((VAR_MODE != 0) ? held_d : drv_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fval_q    <= '0;
            held_q    <= '0;
            out_q     <= '0;
            timer_q   <= '0;
            forced_q  <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            fval_q    <= fval_d;
            held_q    <= held_d;
            out_q     <= out_d;
            timer_q   <= timer_d;
            forced_q  <= forced_d;
            expired_q <= expire;
        end
    end

    assign out_o     = out_q;
    assign forced_o  = forced_q;
    assign expired_o = expired_q;
endmodule

// File: rtl/force_release_bank.sv
// Multi-channel force/release controller: accepts a command, applies it the next cycle.
// Latency: outputs registered, force visible the cycle after APPLY; ready drops during APPLY.
module force_release_bank
    import force_release_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int W        = 4,
    parameter int DW       = 8,
    parameter int VAR_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    force_release_bank_if.slave  cmd,
    input  logic [NCH*W-1:0]     drv_value,
    input  logic [NCH-1:0]       drv_we,
    output logic [NCH*W-1:0]     out_value,
    output logic [NCH-1:0]       forced,
    output logic [NCH-1:0]       expired,
    output logic                 cmd_err
);
    localparam int CW = chan_width(NCH);

    state_t        state_q, state_d;
    op_t           op_q;
    logic [CW-1:0] chan_q;
    logic [W-1:0]  value_q;
    logic [DW-1:0] dur_q;

    logic           ready;
    logic           apply_en;
    logic           accept;
    logic           chan_ok;
    logic [NCH-1:0] sel;
    logic [NCH-1:0] force_vec;
    logic [NCH-1:0] rel_vec;
    logic           err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd.cmd_valid) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        apply_en = 1'b0;
        case (state_q)
            ST_IDLE:  ready    = 1'b1;
            ST_APPLY: apply_en = 1'b1;
            default:  ready    = 1'b0;
        endcase
    end

    assign cmd.cmd_ready = ready;
    assign accept        = cmd.cmd_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_NOP;
            chan_q  <= '0;
            value_q <= '0;
            dur_q   <= '0;
        end else if (accept) begin
            op_q    <= op_t'(cmd.cmd_op);
            chan_q  <= cmd.cmd_chan;
            value_q <= cmd.cmd_value;
            dur_q   <= cmd.cmd_dur;
        end
    end

    // Channel index may exceed NCH when NCH is not a power of two.
    always_comb begin
        chan_ok   = 32'(chan_q) < 32'(NCH);
        sel       = chan_ok ? (NCH'(1) << chan_q) : '0;
        force_vec = '0;
        rel_vec   = '0;
        err       = 1'b0;
        if (apply_en) begin
            case (op_q)
                OP_FORCE: begin
                    force_vec = sel;
                    err       = !chan_ok;
                end
                OP_RELEASE: begin
                    rel_vec = sel & forced;
                    err     = !chan_ok || ((sel & forced) == '0);
                end
                OP_RELEASE_ALL: rel_vec = forced;
                default: ;
            endcase
        end
    end

    assign cmd_err = err;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        force_release_chan #(
            .W        (W),
            .DW       (DW),
            .VAR_MODE (VAR_MODE)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .force_i   (force_vec[c]),
            .release_i (rel_vec[c]),
            .fval_i    (value_q),
            .dur_i     (dur_q),
            .drv_i     (drv_value[c*W +: W]),
            .we_i      (drv_we[c]),
            .out_o     (out_value[c*W +: W]),
            .forced_o  (forced[c]),
            .expired_o (expired[c])
        );
    end
endmodule

// File: tb/tb_force_release_bank.sv
// Bench for force_release_bank: a net-mode bank (5 channels) and a variable-mode bank
// (4 channels) run directed scenarios, then random traffic against a reference model.
module tb_force_release_bank;
    import force_release_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_valid [2];
    logic [1:0]  s_op    [2];
    logic [2:0]  s_chan  [2];
    logic [3:0]  s_val   [2];
    logic [7:0]  s_dur   [2];
    logic [19:0] s_drv   [2];
    logic [4:0]  s_we    [2];

    logic [19:0] out_n;
    logic [4:0]  forced_n, expired_n;
    logic        err_n;
    logic [15:0] out_v;
    logic [3:0]  forced_v, expired_v;
    logic        err_v;

    force_release_bank_if #(.NCH(5), .W(4), .DW(8)) if_n ();
    force_release_bank_if #(.NCH(4), .W(4), .DW(8)) if_v ();

    assign if_n.cmd_valid = s_valid[0];
    assign if_n.cmd_op    = s_op[0];
    assign if_n.cmd_chan  = s_chan[0];
    assign if_n.cmd_value = s_val[0];
    assign if_n.cmd_dur   = s_dur[0];
    assign if_v.cmd_valid = s_valid[1];
    assign if_v.cmd_op    = s_op[1];
    assign if_v.cmd_chan  = s_chan[1][1:0];
    assign if_v.cmd_value = s_val[1];
    assign if_v.cmd_dur   = s_dur[1];

    force_release_bank #(.NCH(5), .W(4), .DW(8), .VAR_MODE(0)) dut_n (
        .clk(clk), .reset(rst), .cmd(if_n),
        .drv_value(s_drv[0]), .drv_we(s_we[0]),
        .out_value(out_n), .forced(forced_n), .expired(expired_n), .cmd_err(err_n)
    );

    force_release_bank #(.NCH(4), .W(4), .DW(8), .VAR_MODE(1)) dut_v (
        .clk(clk), .reset(rst), .cmd(if_v),
        .drv_value(s_drv[1][15:0]), .drv_we(s_we[1][3:0]),
        .out_value(out_v), .forced(forced_v), .expired(expired_v), .cmd_err(err_v)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: per-channel force state, remaining visible cycles, held value.
    bit         mf   [2][5];
    logic [3:0] mfv  [2][5];
    logic [3:0] mh   [2][5];
    int         ml   [2][5];
    logic [3:0] mo   [2][5];
    bit         mx   [2][5];
    bit         tch  [2][5];
    bit         busy [2];
    logic [1:0] bop  [2];
    int         bch  [2];
    logic [3:0] bval [2];
    int         bdur [2];

    function automatic int nch(input int d);
        return (d == 0) ? 5 : 4;
    endfunction

    task automatic m_release(input int d, input int c);
        mf[d][c] = 1'b0;
        ml[d][c] = 0;
        mh[d][c] = mfv[d][c];
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                busy[d] = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    mf[d][c] = 0; mfv[d][c] = 0; mh[d][c] = 0;
                    ml[d][c] = 0; mo[d][c] = 0; mx[d][c] = 0;
                end
            end else begin
                for (int c = 0; c < 5; c++) begin
                    mx[d][c]  = 1'b0;
                    tch[d][c] = 1'b0;
                    if (s_we[d][c] && !mf[d][c]) mh[d][c] = s_drv[d][c*4 +: 4];
                end
                if (busy[d]) begin
                    case (bop[d])
                        2'd1: if (bch[d] < nch(d)) begin
                            mf[d][bch[d]]  = 1'b1;
                            mfv[d][bch[d]] = bval[d];
                            ml[d][bch[d]]  = bdur[d];
                            tch[d][bch[d]] = 1'b1;
                        end
                        2'd2: if (bch[d] < nch(d)) begin
                            if (mf[d][bch[d]]) begin
                                m_release(d, bch[d]);
                                tch[d][bch[d]] = 1'b1;
                            end
                        end
                        2'd3: for (int c = 0; c < nch(d); c++) begin
                            if (mf[d][c]) begin
                                m_release(d, c);
                                tch[d][c] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                for (int c = 0; c < nch(d); c++) begin
                    if (!tch[d][c] && mf[d][c] && ml[d][c] != 0) begin
                        ml[d][c]--;
                        if (ml[d][c] == 0) begin
                            m_release(d, c);
                            mx[d][c] = 1'b1;
                        end
                    end
                    mo[d][c] = mf[d][c] ? mfv[d][c] : ((d == 1) ? mh[d][c] : s_drv[d][c*4 +: 4]);
                end
                if (busy[d]) begin
                    busy[d] = 1'b0;
                end else if (s_valid[d]) begin
                    busy[d] = 1'b1;
                    bop[d]  = s_op[d];
                    bch[d]  = (d == 1) ? int'(s_chan[d][1:0]) : int'(s_chan[d]);
                    bval[d] = s_val[d];
                    bdur[d] = int'(s_dur[d]);
                end
            end
        end
    end

    function automatic bit m_err(input int d);
        if (!busy[d]) return 1'b0;
        if (bop[d] == 2'd1) return bch[d] >= nch(d);
        if (bop[d] == 2'd2) return (bch[d] >= nch(d)) ? 1'b1 : !mf[d][bch[d]];
        return 1'b0;
    endfunction

    function automatic logic [19:0] m_out(input int d);
        logic [19:0] v = '0;
        for (int c = 0; c < nch(d); c++) v[c*4 +: 4] = mo[d][c];
        return v;
    endfunction

    function automatic logic [4:0] m_bits(input int d, input bit pick_exp);
        logic [4:0] v = '0;
        for (int c = 0; c < nch(d); c++) v[c] = pick_exp ? mx[d][c] : mf[d][c];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_n",     32'(out_n),         32'(m_out(0)));
            chk("forced_n",  32'(forced_n),      32'(m_bits(0, 1'b0)));
            chk("expired_n", 32'(expired_n),     32'(m_bits(0, 1'b1)));
            chk("err_n",     32'(err_n),         32'(m_err(0)));
            chk("ready_n",   32'(if_n.cmd_ready), 32'(!busy[0]));
            chk("out_v",     32'(out_v),         32'(m_out(1)));
            chk("forced_v",  32'(forced_v),      32'(m_bits(1, 1'b0)));
            chk("expired_v", 32'(expired_v),     32'(m_bits(1, 1'b1)));
            chk("err_v",     32'(err_v),         32'(m_err(1)));
            chk("ready_v",   32'(if_v.cmd_ready), 32'(!busy[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int d, input logic [1:0] op, input int ch, input logic [3:0] v, input int dur);
        s_valid[d] = 1'b1;
        s_op[d]    = op;
        s_chan[d]  = 3'(ch);
        s_val[d]   = v;
        s_dur[d]   = 8'(dur);
        tick();
        s_valid[d] = 1'b0;
    endtask

    initial begin
        int n9, nx, n6;
        logic ex0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 0; s_op[d] = 0; s_chan[d] = 0; s_val[d] = 0;
            s_dur[d] = 0; s_drv[d] = 0; s_we[d] = 0;
        end
        repeat (2) tick();
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("rst_out",    32'(out_n),          32'h0);
        chk("rst_forced", 32'(forced_n),       32'h0);
        chk("rst_ready",  32'(if_n.cmd_ready), 32'h1);
        tick();

        // Net mode force / release.
        s_drv[0][7:4] = 4'h3;
        tick();
        send(0, OP_FORCE, 1, 4'h5, 0);
        tick();
        @(negedge clk); chk("net_force", 32'(out_n[7:4]), 32'h5);
        tick();
        send(0, OP_RELEASE, 1, 4'h0, 0);
        tick();
        @(negedge clk); chk("net_release", 32'(out_n[7:4]), 32'h3);
        tick();

        // Timed force lasting 3 cycles.
        s_drv[0][11:8] = 4'hE;
        send(0, OP_FORCE, 2, 4'h9, 3);
        n9 = 0; nx = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_n[11:8] == 4'h9) n9++;
            if (expired_n[2]) nx++;
        end
        chk("timed_len",   32'(n9), 32'd3);
        chk("timed_exp",   32'(nx), 32'd1);
        chk("timed_after", 32'(out_n[11:8]), 32'hE);
        tick();

        // Errors: release of unforced channel, out-of-range channel.
        send(0, OP_RELEASE, 3, 4'h0, 0);
        @(negedge clk); chk("rel_unforced_err", 32'(err_n), 32'h1);
        tick();
        @(negedge clk); chk("err_pulse_end", 32'(err_n), 32'h0);
        tick();
        send(0, OP_FORCE, 5, 4'hF, 0);
        @(negedge clk); chk("bad_chan_err", 32'(err_n), 32'h1);
        tick(); tick();
        @(negedge clk); chk("bad_chan_nostate", 32'(forced_n), 32'h0);
        tick();

        // Re-force lands in the same cycle the previous force would expire.
        send(0, OP_FORCE, 2, 4'h9, 3);
        tick(); tick();
        send(0, OP_FORCE, 2, 4'h6, 4);
        @(negedge clk);
        n6 = 0; ex0 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) ex0 = expired_n[2];
            if (out_n[11:8] == 4'h6) n6++;
        end
        chk("reforce_noexp", 32'(ex0), 32'h0);
        chk("reforce_len",   32'(n6),  32'd4);
        tick();

        // Release-all with two forced channels.
        send(0, OP_FORCE, 0, 4'h1, 0);
        tick();
        send(0, OP_FORCE, 3, 4'h2, 0);
        tick();
        send(0, OP_RELEASE_ALL, 0, 4'h0, 0);
        @(negedge clk); chk("rel_all_err", 32'(err_n), 32'h0);
        tick();
        @(negedge clk); chk("rel_all_forced", 32'(forced_n), 32'h0);
        tick();

        // Reset during APPLY of a force.
        send(0, OP_FORCE, 4, 4'hB, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_apply_forced", 32'(forced_n),       32'h0);
        chk("rst_apply_out",    32'(out_n),          32'h0);
        chk("rst_apply_ready",  32'(if_n.cmd_ready), 32'h1);
        tick();

        // Variable mode: writes while forced are lost, release keeps forced value.
        s_drv[1][3:0] = 4'hA; s_we[1][0] = 1'b1;
        tick();
        s_we[1][0] = 1'b0;
        send(1, OP_FORCE, 0, 4'h5, 0);
        tick();
        s_drv[1][3:0] = 4'hC; s_we[1][0] = 1'b1;
        tick();
        s_we[1][0] = 1'b0;
        @(negedge clk); chk("var_forced_write", 32'(out_v[3:0]), 32'h5);
        tick();
        send(1, OP_RELEASE, 0, 4'h0, 0);
        tick();
        @(negedge clk); chk("var_release_hold", 32'(out_v[3:0]), 32'h5);
        tick();
        s_drv[1][3:0] = 4'h7; s_we[1][0] = 1'b1;
        tick();
        s_we[1][0] = 1'b0;
        @(negedge clk); chk("var_write_after", 32'(out_v[3:0]), 32'h7);
        tick();

        // Random traffic on both banks.
        repeat (3000) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int d = 0; d < 2; d++) begin
                int r;
                s_valid[d] = ($urandom_range(0, 2) == 0);
                r = $urandom_range(0, 9);
                s_op[d]   = (r < 5) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd3 : 2'd0;
                s_chan[d] = 3'($urandom_range(0, (d == 0) ? 7 : 3));
                s_val[d]  = 4'($urandom);
                s_dur[d]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
                if ($urandom_range(0, 3) == 0) s_drv[d] = 20'($urandom);
                s_we[d]   = 5'($urandom) & ((d == 0) ? 5'h1F : 5'h0F);
            end
            tick();
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            s_we[d]    = '0;
        end
        repeat (4) tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
